// File: rtl/game_pkg.sv
// game_pkg: shared states, screen codes and score limits for the whack-a-box sequencer.
package game_pkg;
  typedef enum logic [2:0] {LOBBY, PICK, ROUND, HIT_HOLD, GAME_OVER} state_t;
  localparam logic [2:0] MIF_LOBBY = 3'd0;
  localparam logic [2:0] MIF_GAME_OVER = 3'd7;
  localparam int SCORE_W = 11;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 11'd2047;
  // A new target must be a real box and never repeat the previous one.
  function automatic logic valid_pick(input logic [2:0] v, input logic [2:0] last, input int n);
    return v != 3'd0 && int'(v) <= n && v != last;
  endfunction
endpackage

// File: rtl/game_sequencer_sec_prescaler.sv
// sec_prescaler: counts CLK_HZ enabled cycles and emits a one-cycle tick on the last one.
module sec_prescaler #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);
  logic [W-1:0] count_q, count_d;
  always_comb begin
    tick = en && count_q == LAST;
    count_d = clr ? '0 : !en ? count_q : tick ? '0 : count_q + 1'b1;
  end
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: lobby/round/game-over controller with target pick, hit scoring and game clock.
// Define MISS_PENALTY_EN to make wrong-box strikes during a round cost one point.
module game_sequencer
  import game_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int GAME_SECONDS = 60,
  parameter int ROUND_CYCLES = 75_000_000,
  parameter int HIT_SOUND_CYCLES = 25_000_000,
  parameter int NUM_BOXES = 6
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start_btn,
  input  logic [2:0]         box_address,
  input  logic [2:0]         lfsr_value,
  output logic [2:0]         mif_select,
  output logic [SCORE_W-1:0] score,
  output logic [5:0]         seconds_left,
  output logic               round_active,
  output logic               hit_pulse,
  output logic               lobby_sound_en,
  output logic               hit_sound_en,
  output logic               game_over
);
  localparam int TMAX = ROUND_CYCLES > HIT_SOUND_CYCLES ? ROUND_CYCLES : HIT_SOUND_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  state_t state_q, state_d;
  logic [2:0] s1_q, s2_q, prev_q, strike_q, strike_d, target_q, target_d, mif_q, mif_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [5:0] sec_q, sec_d;
  logic round_active_q, round_active_d, hit_pulse_q, hit_pulse_d;
  logic lobby_q, lobby_d, hit_snd_q, hit_snd_d, game_over_q, game_over_d;
  logic en, clr, tick, penalty;
  sec_prescaler #(.CLK_HZ(CLK_HZ)) u_presc (
    .CLOCK_50(CLOCK_50), .reset(reset), .en(en), .clr(clr), .tick(tick)
  );
  always_comb begin
    en = state_q == PICK || state_q == ROUND || state_q == HIT_HOLD;
    // strike_q is a registered edge: a new non-zero code seen after the synchronizer
    strike_d = (s2_q != 3'd0 && s2_q != prev_q) ? s2_q : 3'd0;
`ifdef MISS_PENALTY_EN
    penalty = strike_q != 3'd0 && strike_q != target_q;
`else
    penalty = 1'b0;
`endif
    state_d = state_q;
    target_d = target_q;
    timer_d = timer_q;
    score_d = score_q;
    sec_d = sec_q;
    hit_pulse_d = 1'b0;
    clr = 1'b0;
    case (state_q)
      LOBBY: if (start_btn) begin
        score_d = '0;
        sec_d = 6'(GAME_SECONDS);
        clr = 1'b1;
        state_d = PICK;
      end
      PICK: if (valid_pick(lfsr_value, target_q, NUM_BOXES)) begin
        target_d = lfsr_value;
        timer_d = TW'(ROUND_CYCLES);
        state_d = ROUND;
      end
      ROUND: if (strike_q == target_q) begin
        score_d = score_q == SCORE_MAX ? score_q : score_q + 1'b1;
        hit_pulse_d = 1'b1;
        timer_d = TW'(HIT_SOUND_CYCLES);
        state_d = HIT_HOLD;
      end else begin
        score_d = (penalty && score_q != '0) ? score_q - 1'b1 : score_q;
        timer_d = timer_q - 1'b1;
        state_d = timer_q == TW'(1) ? PICK : ROUND;
      end
      HIT_HOLD: begin
        timer_d = timer_q - 1'b1;
        state_d = timer_q == TW'(1) ? PICK : HIT_HOLD;
      end
      GAME_OVER: if (start_btn) state_d = LOBBY;
      default: state_d = LOBBY;
    endcase
    // The final tick overrides any round outcome, but a same-cycle hit still scores.
    if (tick) begin
      sec_d = sec_q - 1'b1;
      if (sec_q == 6'd1) state_d = GAME_OVER;
    end
    round_active_d = state_d == ROUND;
    game_over_d = state_d == GAME_OVER;
    hit_snd_d = state_d == HIT_HOLD;
    lobby_d = state_d == LOBBY && !hit_snd_d;
    mif_d = state_d == LOBBY ? MIF_LOBBY : state_d == GAME_OVER ? MIF_GAME_OVER :
            state_d == ROUND ? target_d : mif_q;
  end
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state_q <= LOBBY;
      s1_q <= '0;
      s2_q <= '0;
      prev_q <= '0;
      strike_q <= '0;
      target_q <= '0;
      timer_q <= '0;
      mif_q <= MIF_LOBBY;
      score_q <= '0;
      sec_q <= 6'(GAME_SECONDS);
      round_active_q <= 1'b0;
      hit_pulse_q <= 1'b0;
      lobby_q <= 1'b0;
      hit_snd_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q <= box_address;
      s2_q <= s1_q;
      prev_q <= s2_q;
      strike_q <= strike_d;
      target_q <= target_d;
      timer_q <= timer_d;
      mif_q <= mif_d;
      score_q <= score_d;
      sec_q <= sec_d;
      round_active_q <= round_active_d;
      hit_pulse_q <= hit_pulse_d;
      lobby_q <= lobby_d;
      hit_snd_q <= hit_snd_d;
      game_over_q <= game_over_d;
    end
  assign mif_select = mif_q;
  assign score = score_q;
  assign seconds_left = sec_q;
  assign round_active = round_active_q;
  assign hit_pulse = hit_pulse_q;
  assign lobby_sound_en = lobby_q;
  assign hit_sound_en = hit_snd_q;
  assign game_over = game_over_q;
endmodule
